// File: rtl/lamp_toggle_receiver.sv
// lamp_toggle_receiver: collects one-cycle trigger pulses per wire line,
// accumulates toggle parity per window, commits on a logic tick and offers
// the new lamp states downstream with a valid/ready handshake.
// Optional feature macro: LAMP_FAULT_EN (per-line double-trigger fault lamp).

// Per-line lamp slice: toggle parity, lamp state, last-commit mask and,
// when enabled, a saturating per-window trigger count.
module lamp_lane (
  input  logic clk,
  input  logic logic_reset,
  input  logic commit,
  input  logic trig,
  output logic pending,
  output logic lamp,
  output logic flipped
`ifdef LAMP_FAULT_EN
  ,
  output logic over
`endif
);

  // Parity accumulation runs every cycle; on commit the window closes and the
  // pulse seen in the commit cycle seeds the next window.
  always_ff @(posedge clk or negedge logic_reset) begin
    if (!logic_reset) begin
      pending <= 1'b0;
      lamp    <= 1'b0;
      flipped <= 1'b0;
    end else if (commit) begin
      lamp    <= lamp ^ pending;
      flipped <= pending;
      pending <= trig;
    end else begin
      pending <= pending ^ trig;
    end
  end

`ifdef LAMP_FAULT_EN
  logic [1:0] cnt;
  logic [1:0] cnt_nxt;

  // Next trigger count: reseeded on commit, saturates at 3 otherwise.
  always_comb begin
    cnt_nxt = cnt;
    if (commit)
      cnt_nxt = {1'b0, trig};
    else if (trig && (cnt != 2'd3))
      cnt_nxt = cnt + 2'd1;
  end

  // Trigger count register for the open window.
  always_ff @(posedge clk or negedge logic_reset) begin
    if (!logic_reset) cnt <= 2'd0;
    else              cnt <= cnt_nxt;
  end

  // Two or more triggers in one window flags this line.
  assign over = cnt_nxt[1];
`endif

endmodule

module lamp_toggle_receiver #(
  parameter int INPUT_COUNT = 2
) (
  input  logic                   clk,
  input  logic                   logic_reset,
  input  logic                   tick,
  input  logic [INPUT_COUNT-1:0] in,
  output logic [INPUT_COUNT-1:0] out,
  output logic [INPUT_COUNT-1:0] changed,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   tick_dropped,
  output logic                   fault
);

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    COMMIT = 2'd1,
    NOTIFY = 2'd2
  } state_t;

  state_t                 state;
  logic                   commit;
  logic [INPUT_COUNT-1:0] pending;
`ifdef LAMP_FAULT_EN
  logic [INPUT_COUNT-1:0] over;
`endif

  assign commit = (state == COMMIT);

  genvar g;
  generate
    for (g = 0; g < INPUT_COUNT; g++) begin : g_lane
      lamp_lane u_lane (
        .clk         (clk),
        .logic_reset (logic_reset),
        .commit      (commit),
        .trig        (in[g]),
        .pending     (pending[g]),
        .lamp        (out[g]),
        .flipped     (changed[g])
`ifdef LAMP_FAULT_EN
        ,
        .over        (over[g])
`endif
      );
    end
  endgenerate

  // Window sequencing and handshake: a commit that flips nothing skips NOTIFY.
  always_ff @(posedge clk or negedge logic_reset) begin
    if (!logic_reset) begin
      state     <= ACCUM;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (tick) state <= COMMIT;
        end
        COMMIT: begin
          if (|pending) begin
            state     <= NOTIFY;
            out_valid <= 1'b1;
          end else begin
            state <= ACCUM;
          end
        end
        NOTIFY: begin
          if (out_valid && out_ready) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ACCUM;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Ticks that land while a commit is still in flight are flagged, not queued.
  always_ff @(posedge clk or negedge logic_reset) begin
    if (!logic_reset) tick_dropped <= 1'b0;
    else              tick_dropped <= tick && (state != ACCUM);
  end

`ifdef LAMP_FAULT_EN
  // Sticky fault lamp: any line double-triggered within a window.
  always_ff @(posedge clk or negedge logic_reset) begin
    if (!logic_reset) fault <= 1'b0;
    else              fault <= fault | (|over);
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_lamp_toggle_receiver.sv
module tb_lamp_toggle_receiver;

  logic       clk = 1'b0;
  logic       logic_reset = 1'b0;
  logic       tick4 = 1'b0, tick1 = 1'b0;
  logic [3:0] in4 = '0;
  logic [0:0] in1 = '0;
  logic       rdy4 = 1'b0, rdy1 = 1'b0;
  logic [3:0] out4, chg4;
  logic [0:0] out1, chg1;
  logic       vld4, vld1, drop4, drop1, fault4, fault1;

  int nvec = 0;
  int nerr = 0;

`ifdef LAMP_FAULT_EN
  localparam logic FAULT_EXP = 1'b1;
`else
  localparam logic FAULT_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  lamp_toggle_receiver #(.INPUT_COUNT(4)) u_dut4 (
    .clk(clk), .logic_reset(logic_reset), .tick(tick4), .in(in4),
    .out(out4), .changed(chg4), .out_valid(vld4), .out_ready(rdy4),
    .tick_dropped(drop4), .fault(fault4)
  );

  lamp_toggle_receiver #(.INPUT_COUNT(1)) u_dut1 (
    .clk(clk), .logic_reset(logic_reset), .tick(tick1), .in(in1),
    .out(out1), .changed(chg1), .out_valid(vld1), .out_ready(rdy1),
    .tick_dropped(drop1), .fault(fault1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: inputs set at the negedge are taken at the next posedge;
  // outputs are inspected at the following negedge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    logic_reset = 1'b0;
    cyc();
    logic_reset = 1'b1;
    cyc();
  endtask

  int drops;

  initial begin
    @(negedge clk);
    // reset state
    chk("rst_out", out4, 4'b0000);
    chk("rst_chg", chg4, 4'b0000);
    chk("rst_vld", vld4, 1'b0);
    chk("rst_drop", drop4, 1'b0);
    chk("rst_fault", fault4, 1'b0);
    logic_reset = 1'b1;
    cyc();

    // 1: pulse 0101, tick two cycles later, then accept
    in4 = 4'b0101; cyc(); in4 = '0;
    cyc();
    tick4 = 1'b1; cyc(); tick4 = 1'b0;
    chk("t1_vld_commit", vld4, 1'b0);
    cyc();
    chk("t1_out", out4, 4'b0101);
    chk("t1_chg", chg4, 4'b0101);
    chk("t1_vld", vld4, 1'b1);
    rdy4 = 1'b1; cyc(); rdy4 = 1'b0;
    chk("t1_vld_acc", vld4, 1'b0);
    chk("t1_out_hold", out4, 4'b0101);

    // 2: line 1 pulsed twice in one window cancels; fault lamp if enabled
    do_reset();
    in4 = 4'b0010; cyc();
    chk("t2_fault_one", fault4, 1'b0);
    cyc(); in4 = '0;
    chk("t2_fault", fault4, FAULT_EXP);
    tick4 = 1'b1; cyc(); tick4 = 1'b0;
    cyc();
    chk("t2_out", out4, 4'b0000);
    chk("t2_chg", chg4, 4'b0000);
    chk("t2_vld", vld4, 1'b0);
    cyc();
    chk("t2_vld_later", vld4, 1'b0);
    tick4 = 1'b1; cyc(); tick4 = 1'b0; cyc();
    chk("t2_fault_sticky", fault4, FAULT_EXP);
    chk("t2_drop", drop4, 1'b0);

    // 3: pulse with the tick closes that window; commit-cycle pulse opens the next
    do_reset();
    in4 = 4'b0001; tick4 = 1'b1; cyc(); tick4 = 1'b0;
    in4 = 4'b0010; cyc(); in4 = '0;
    chk("t3_out_a", out4, 4'b0001);
    chk("t3_chg_a", chg4, 4'b0001);
    chk("t3_vld_a", vld4, 1'b1);
    rdy4 = 1'b1; cyc(); rdy4 = 1'b0;
    tick4 = 1'b1; cyc(); tick4 = 1'b0; cyc();
    chk("t3_out_b", out4, 4'b0011);
    chk("t3_chg_b", chg4, 4'b0010);
    rdy4 = 1'b1; cyc(); rdy4 = 1'b0;

    // 4: stalled NOTIFY with a tick on its third cycle is dropped; toggles carry
    do_reset();
    in4 = 4'b1000; cyc(); in4 = '0;
    tick4 = 1'b1; cyc(); tick4 = 1'b0; cyc();
    chk("t4_vld", vld4, 1'b1);
    drops = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) in4 = 4'b0100;
      if (i == 2) tick4 = 1'b1;
      cyc();
      in4 = '0; tick4 = 1'b0;
      if (drop4) drops++;
      chk("t4_out_stable", out4, 4'b1000);
      chk("t4_chg_stable", chg4, 4'b1000);
    end
    chk("t4_drop_count", drops, 1);
    rdy4 = 1'b1; cyc(); rdy4 = 1'b0;
    chk("t4_vld_acc", vld4, 1'b0);
    tick4 = 1'b1; cyc(); tick4 = 1'b0; cyc();
    chk("t4_out_carry", out4, 4'b1100);
    chk("t4_chg_carry", chg4, 4'b0100);
    rdy4 = 1'b1; cyc(); rdy4 = 1'b0;

    // 5: asynchronous reset mid-NOTIFY
    do_reset();
    in4 = 4'b1010; cyc(); in4 = '0;
    tick4 = 1'b1; cyc(); tick4 = 1'b0; cyc();
    chk("t5_out_pre", out4, 4'b1010);
    #2 logic_reset = 1'b0;
    #1;
    chk("t5_out_async", out4, 4'b0000);
    chk("t5_chg_async", chg4, 4'b0000);
    chk("t5_vld_async", vld4, 1'b0);
    @(negedge clk);
    logic_reset = 1'b1;
    cyc();
    in4 = 4'b1000; cyc(); in4 = '0;
    tick4 = 1'b1; cyc(); tick4 = 1'b0; cyc();
    chk("t5_out_post", out4, 4'b1000);
    chk("t5_vld_post", vld4, 1'b1);

    // 6: single line, trigger every cycle, tick every 3 cycles, ready tied high
    do_reset();
    in1 = 1'b1; rdy1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick1 = 1'b1; cyc(); tick1 = 1'b0;
      chk("t6_drop_c", drop1, 1'b0);
      cyc();
      chk("t6_out", out1, (k % 2 == 0) ? 1'b1 : 1'b0);
      chk("t6_vld", vld1, 1'b1);
      chk("t6_drop_n", drop1, 1'b0);
      cyc();
      chk("t6_drop_a", drop1, 1'b0);
    end
    in1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/lamp_toggle_receiver.md
# lamp_toggle_receiver

Receiving end of the gate output path: collects one-cycle trigger pulses arriving on wire lines and toggles one lamp bit per line. Toggles are committed only on a logic tick. After a commit that changed anything, the block presents the new lamp states with a valid/ready handshake to the downstream gate evaluator (the Gate_* blocks that read lamp states). It sits between the gate outputs / wire network and the next gate stage's `in` bus.

## Interface
- `INPUT_COUNT`, default 2: number of wire lines and lamps; must be ≥1.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `logic_reset`  input  1  asynchronous, active-low reset.
- `tick`  input  1  one-cycle logic tick strobe; commits accumulated toggles.
- `in`  input  INPUT_COUNT  trigger pulses; bit i high for one cycle = one trigger on line i.
- `out`  output  INPUT_COUNT  committed lamp states.
- `changed`  output  INPUT_COUNT  lamps flipped by the last commit.
- `out_valid`  output  1  `out`/`changed` hold a new, unacknowledged commit.
- `out_ready`  input  1  downstream accepts the commit.
- `tick_dropped`  output  1  one-cycle pulse: `tick` arrived outside ACCUM and was ignored.
- `fault`  output  1  sticky fault lamp; behaviour depends on configuration.

## Operation
- Registers:
  - `pending[INPUT_COUNT]`: toggle parity per line.
  - `out`, `changed`: lamp state and last-commit mask.
  - A 2-bit state.
- Trigger accumulation: in every state, including COMMIT and NOTIFY, each high `in[i]` XORs into `pending[i]`. An even number of triggers within one window cancels.
- ACCUM:
  - `tick`=1 → COMMIT.
  - The `in` sampled in the tick cycle belongs to the closing window.
- COMMIT (exactly 1 cycle):
  - `out <= out ^ pending`
  - `changed <= pending`
  - `pending <= in` (the COMMIT-cycle pulses open the next window)
  - Next state: NOTIFY if `pending`≠0, else ACCUM. `changed` still updates to 0 in the ACCUM case.
- NOTIFY:
  - `out_valid`=1; `out` and `changed` are held stable.
  - `out_valid`&&`out_ready` → ACCUM.
- Tick outside ACCUM (COMMIT or NOTIFY): the tick is ignored, `tick_dropped` pulses the next cycle, and pending toggles carry to the next accepted tick.
- Reset:
  - `out`=0, `changed`=0, `pending`=0, `out_valid`=0, `tick_dropped`=0, `fault`=0, state=ACCUM.
  - Reset mid-NOTIFY discards the unacknowledged commit.
- `out_ready` while not in NOTIFY: ignored.

## Timing
- Tick in cycle T (ACCUM):
  - COMMIT in T+1.
  - New `out`/`changed`/`out_valid`=1 visible in T+2.
- Accept (valid&&ready) in cycle N: `out_valid`=0 in N+1. A tick in N+1 is accepted.
- Minimum tick-to-tick spacing without drop:
  - 2 cycles when the commit changes nothing (T, T+2).
  - 3 cycles when `out_ready` is tied high.
- `tick_dropped` is registered: high the cycle after the ignored tick, for 1 cycle.
- Combinational paths: none from inputs to outputs; all outputs come from flops.

## Configuration
- `LAMP_FAULT_EN` defined:
  - Adds a per-line 2-bit saturating trigger count per window, cleared at COMMIT together with `pending`; a COMMIT-cycle pulse seeds it to 1.
  - Any line reaching ≥2 triggers in one window sets `fault`=1 the next cycle.
  - `fault` is sticky until `logic_reset`; toggling is unaffected.
- `LAMP_FAULT_EN` undefined: no counters; `fault` tied to 0.

## Test plan
- Reset, INPUT_COUNT=4: pulse `in`=4'b0101 once, tick 2 cycles later → 2 cycles after tick `out`=0101, `changed`=0101, `out_valid`=1; `out_ready`=1 → `out_valid`=0 next cycle.
- Line 1 pulsed twice in a window, then tick → no NOTIFY, `out` unchanged, `changed`=0, `out_valid` never rises. With `LAMP_FAULT_EN`, `fault`=1 one cycle after the second pulse and it stays 1 through further ticks.
- `in`=0001 pulsed in the same cycle as `tick`, then `in`=0010 pulsed in the COMMIT cycle → `out`=0001 after the first commit; the next tick yields `out`=0011, `changed`=0010.
- `out_ready` held 0 for 5 cycles in NOTIFY with `tick` pulsed on the third of them → `tick_dropped` pulses once, `out`/`changed` stable; after accept, the next tick commits the carried toggles.
- Assert `logic_reset` low asynchronously mid-NOTIFY with `out`=1010 → all outputs 0 immediately. After release, a single `in[3]` pulse plus tick gives `out`=1000.
- INPUT_COUNT=1, every cycle `in`=1 and ticks every 3 cycles with `out_ready`=1 → `out` flips per odd-count window; `tick_dropped` never asserts.
